// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM state encodings,
// frame shape constants and the parity helper.
package ps2_kbd_rx_pkg;

    // Receiver FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Frame shape: start, 8 data bits LSB first, odd parity, stop
    localparam int   DATA_BITS  = 8;
    localparam logic PARITY_ODD = 1'b1;

    // True when the data bits plus the parity bit satisfy odd parity
    function automatic logic parity_ok(input logic [DATA_BITS:0] bits);
        return (^bits) == PARITY_ODD;
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_fifo.sv
// Small first-word fall-through scancode FIFO. Register-array storage,
// pointers wrap modulo DEPTH (power of two), separate occupancy count.
module ps2_rx_fifo
    import ps2_kbd_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk50,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic                 full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic                 pop_eff;
    logic                 push_eff;

    assign valid    = (count_reg != '0);
    assign full     = (count_reg == CW'(DEPTH));
    // Pop of an empty FIFO is ignored; a push into a full FIFO only lands
    // when a pop frees a slot in the same cycle.
    assign pop_eff  = pop & valid;
    assign push_eff = push & (~full | pop_eff);
    // Head entry is presented combinationally; forced to zero when empty so
    // the output is clean after reset.
    assign dout     = valid ? mem[rd_ptr_reg] : '0;

    // Storage array: cleared on reset, written at the write pointer
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_eff) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_eff && !pop_eff) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_eff && !push_eff) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 lines,
// deframes 11-bit device-to-host frames, checks parity/framing and a frame
// timeout, and buffers good scancodes in a FWFT FIFO.
module ps2_kbd_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    input  logic       ovf_clr,
    output logic [7:0] dout,
    output logic       valid,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [1:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic          clk_s;
    logic          data_s;
    logic [FW-1:0] filt_cnt_reg;
    logic          filt_reg;
    logic          fall_reg;

    state_t        state_reg,      state_next;
    logic [2:0]    bitcnt_reg,     bitcnt_next;
    logic [7:0]    shreg_reg,      shreg_next;
    logic          par_ok_reg,     par_ok_next;
    logic [TW-1:0] tcnt_reg,       tcnt_next;
    logic          push_reg,       push_next;
    logic          err_parity_reg, err_parity_next;
    logic          err_frame_reg,  err_frame_next;
    logic          overflow_reg;
    logic          fifo_full;

    assign clk_s  = clk_sync_reg[1];
    assign data_s = data_sync_reg[1];

    // Two-flop synchronisers for both PS/2 lines, preset to the idle level
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
        end
    end

    // Glitch filter on the clock: flip only after FILTER_LEN consecutive
    // samples at the new level; fall_reg marks the 1->0 flip for one cycle.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            filt_cnt_reg <= '0;
            filt_reg     <= 1'b1;
            fall_reg     <= 1'b0;
        end else begin
            fall_reg <= 1'b0;
            if (clk_s != filt_reg) begin
                if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
                    filt_reg     <= clk_s;
                    filt_cnt_reg <= '0;
                    fall_reg     <= ~clk_s;
                end else begin
                    filt_cnt_reg <= filt_cnt_reg + 1'b1;
                end
            end else begin
                filt_cnt_reg <= '0;
            end
        end
    end

    // Frame FSM state, shift register, timeout counter and output pulses
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            bitcnt_reg     <= '0;
            shreg_reg      <= '0;
            par_ok_reg     <= 1'b0;
            tcnt_reg       <= '0;
            push_reg       <= 1'b0;
            err_parity_reg <= 1'b0;
            err_frame_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bitcnt_reg     <= bitcnt_next;
            shreg_reg      <= shreg_next;
            par_ok_reg     <= par_ok_next;
            tcnt_reg       <= tcnt_next;
            push_reg       <= push_next;
            err_parity_reg <= err_parity_next;
            err_frame_reg  <= err_frame_next;
        end
    end

    // Next-state logic: advance on each filtered falling edge; a stalled
    // frame is abandoned when the timeout counter runs out.
    always_comb begin
        state_next      = state_reg;
        bitcnt_next     = bitcnt_reg;
        shreg_next      = shreg_reg;
        par_ok_next     = par_ok_reg;
        push_next       = 1'b0;
        err_parity_next = 1'b0;
        err_frame_next  = 1'b0;

        if (state_reg == ST_IDLE || fall_reg) begin
            tcnt_next = '0;
        end else begin
            tcnt_next = tcnt_reg + 1'b1;
        end

        if (fall_reg) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_next  = ST_DATA;
                        bitcnt_next = '0;
                    end else begin
                        err_frame_next = 1'b1;
                    end
                end
                ST_DATA: begin
                    shreg_next  = {data_s, shreg_reg[7:1]};
                    bitcnt_next = bitcnt_reg + 3'd1;
                    if (bitcnt_reg == LAST_BIT) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_ok_next = parity_ok({shreg_reg, data_s});
                    state_next  = ST_STOP;
                end
                ST_STOP: begin
                    state_next = ST_IDLE;
                    if (!data_s) begin
                        err_frame_next = 1'b1;
                    end else if (!par_ok_reg) begin
                        err_parity_next = 1'b1;
                    end else begin
                        push_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state_reg != ST_IDLE && tcnt_reg == TW'(TIMEOUT_CYC - 1)) begin
            state_next     = ST_IDLE;
            err_frame_next = 1'b1;
            tcnt_next      = '0;
        end
    end

    // Sticky overflow: a push into a full FIFO with no simultaneous pop
    // drops the byte; a new overflow wins over a clear in the same cycle.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (push_reg && fifo_full && !rd) begin
            overflow_reg <= 1'b1;
        end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk50 (clk50),
        .rst   (rst),
        .push  (push_reg),
        .din   (shreg_reg),
        .pop   (rd),
        .dout  (dout),
        .valid (valid),
        .full  (fifo_full)
    );

    assign err_parity = err_parity_reg;
    assign err_frame  = err_frame_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx: behavioural PS/2 device model, scoreboard of
// expected scancodes, error pulse counters; one task per scenario.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 400;
    localparam int FIFO_DEPTH  = 4;
    localparam int HALF        = 40;   // PS/2 clock half period in clk50 cycles

    logic       clk50    = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd       = 1'b0;
    logic       ovf_clr  = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;

    int checks     = 0;
    int failures   = 0;
    int par_pulses = 0;
    int frm_pulses = 0;
    logic [7:0] sb [$];

    ps2_kbd_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk50      (clk50),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd         (rd),
        .ovf_clr    (ovf_clr),
        .dout       (dout),
        .valid      (valid),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .overflow   (overflow)
    );

    always #5 clk50 = ~clk50;

    // Count error pulses; the two error outputs must never coincide
    always @(negedge clk50) begin
        if (!rst) begin
            if (err_parity) par_pulses++;
            if (err_frame)  frm_pulses++;
            if (err_parity || err_frame) begin
                checks++;
                if (err_parity && err_frame) begin
                    failures++;
                    $display("FAIL err_exclusive: err_parity=%0b err_frame=%0b required not both 1", err_parity, err_frame);
                end
            end
        end
    end

    // {stop, parity, data[7:0], start}; bad_par inverts the correct odd parity
    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        return {stop, (~(^b)) ^ bad_par, b, 1'b0};
    endfunction

    // Device model: drive the first n bits of a frame, data set while clock is high
    task automatic send_bits(input logic [10:0] frame, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            @(negedge clk50);
            ps2_data = frame[i];
            if (glitch) begin
                repeat (10) @(negedge clk50);
                ps2_clk = 1'b0;
                repeat (5) @(negedge clk50);
                ps2_clk = 1'b1;
                repeat (HALF - 15) @(negedge clk50);
            end else begin
                repeat (HALF) @(negedge clk50);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk50);
            ps2_clk = 1'b1;
        end
        @(negedge clk50);
        ps2_data = 1'b1;
    endtask

    task automatic gap();
        repeat (2 * HALF) @(negedge clk50);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_push, input bit glitch);
        if (expect_push) sb.push_back(b);
        send_bits(make_frame(b, 1'b0, 1'b1), 11, glitch);
        gap();
    endtask

    // Compare the FIFO head against the scoreboard, then pop it
    task automatic pop_check(input string name);
        logic [7:0] exp;
        @(negedge clk50);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, valid=%0b dout=%02h", name, valid, dout);
        end else begin
            exp = sb.pop_front();
            if (valid !== 1'b1 || dout !== exp) begin
                failures++;
                $display("FAIL %s: valid=%0b dout=%02h required valid=1 dout=%02h", name, valid, dout, exp);
            end
        end
        rd = 1'b1;
        @(negedge clk50);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk50);
        checks++;
        if (valid !== 1'b0 || dout !== 8'h00 || overflow !== 1'b0 || err_parity !== 1'b0 || err_frame !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%0b dout=%02h ovf=%0b ep=%0b ef=%0b required all 0",
                     valid, dout, overflow, err_parity, err_frame);
        end
        rst = 1'b0;
        gap();
    endtask

    task automatic test_basic();
        int p0 = par_pulses;
        int f0 = frm_pulses;
        sb.push_back(8'h1C);
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 10, 1'b0);
        repeat (HALF) @(negedge clk50);
        ps2_clk = 1'b0;                       // stop-bit falling edge
        repeat (11) @(negedge clk50);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: valid=%0b required 0 at cycle 11", valid);
        end
        @(negedge clk50);
        checks++;
        if (valid !== 1'b1 || dout !== 8'h1C) begin
            failures++;
            $display("FAIL latency_on_time: valid=%0b dout=%02h required 1/1c at cycle 12", valid, dout);
        end
        repeat (HALF - 12) @(negedge clk50);
        ps2_clk = 1'b1;
        gap();
        checks++;
        if (par_pulses != p0 || frm_pulses != f0) begin
            failures++;
            $display("FAIL basic_no_err: parity pulses=%0d frame pulses=%0d required 0/0", par_pulses - p0, frm_pulses - f0);
        end
        pop_check("basic_1c");
        @(negedge clk50);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_empty: valid=%0b required 0", valid);
        end
    endtask

    task automatic test_parity();
        int p0 = par_pulses;
        int f0 = frm_pulses;
        send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11, 1'b0);
        gap();
        checks++;
        if (par_pulses != p0 + 1 || frm_pulses != f0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL parity_err: parity pulses=%0d frame pulses=%0d valid=%0b required 1/0/0",
                     par_pulses - p0, frm_pulses - f0, valid);
        end
        send_byte(8'hF0, 1'b1, 1'b0);
        pop_check("parity_f0");
    endtask

    task automatic test_frame_err();
        int p0 = par_pulses;
        int f0 = frm_pulses;
        send_bits(make_frame(8'h5A, 1'b0, 1'b0), 11, 1'b0);
        gap();
        checks++;
        if (frm_pulses != f0 + 1 || par_pulses != p0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL stop_err: frame pulses=%0d parity pulses=%0d valid=%0b required 1/0/0",
                     frm_pulses - f0, par_pulses - p0, valid);
        end
        send_bits(11'h7FF, 1, 1'b0);          // lone falling edge with data=1
        gap();
        checks++;
        if (frm_pulses != f0 + 2 || valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_start: frame pulses=%0d valid=%0b required 2/0", frm_pulses - f0, valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
        end
        checks++;
        if (overflow !== 1'b0 || valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_full_no_ovf: overflow=%0b valid=%0b required 0/1", overflow, valid);
        end
        send_byte(8'h05, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: overflow=%0b required 1", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            pop_check("ovf_pop");
        end
        @(negedge clk50);
        checks++;
        if (valid !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drained: valid=%0b overflow=%0b required 0/1", valid, overflow);
        end
        ovf_clr = 1'b1;
        @(negedge clk50);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr: overflow=%0b required 0", overflow);
        end
    endtask

    task automatic test_timeout();
        int f0 = frm_pulses;
        send_bits(make_frame(8'hA5, 1'b0, 1'b1), 5, 1'b0);   // start + 4 data bits
        repeat (TIMEOUT_CYC + TIMEOUT_CYC / 10) @(negedge clk50);
        checks++;
        if (frm_pulses != f0 + 1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout: frame pulses=%0d valid=%0b required 1/0", frm_pulses - f0, valid);
        end
        send_byte(8'h29, 1'b1, 1'b0);
        pop_check("timeout_29");
    endtask

    task automatic test_glitch();
        int p0 = par_pulses;
        int f0 = frm_pulses;
        send_byte(8'h3C, 1'b1, 1'b1);
        checks++;
        if (par_pulses != p0 || frm_pulses != f0) begin
            failures++;
            $display("FAIL glitch_no_err: parity pulses=%0d frame pulses=%0d required 0/0", par_pulses - p0, frm_pulses - f0);
        end
        pop_check("glitch_3c");
    endtask

    task automatic test_midframe_reset();
        int p0;
        int f0;
        send_byte(8'h11, 1'b1, 1'b0);         // leave an entry in the FIFO
        send_bits(make_frame(8'h55, 1'b0, 1'b1), 4, 1'b0);   // start + 3 data bits
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid: valid=%0b required 1", valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || dout !== 8'h00 || overflow !== 1'b0 || err_parity !== 1'b0 || err_frame !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset: valid=%0b dout=%02h ovf=%0b ep=%0b ef=%0b required all 0",
                     valid, dout, overflow, err_parity, err_frame);
        end
        sb.delete();
        @(negedge clk50);
        @(negedge clk50);
        rst = 1'b0;
        gap();
        p0 = par_pulses;
        f0 = frm_pulses;
        send_byte(8'h76, 1'b1, 1'b0);
        checks++;
        if (par_pulses != p0 || frm_pulses != f0) begin
            failures++;
            $display("FAIL after_reset_no_err: parity pulses=%0d frame pulses=%0d required 0/0", par_pulses - p0, frm_pulses - f0);
        end
        pop_check("after_reset_76");
        @(negedge clk50);
        checks++;
        if (valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL final_empty: valid=%0b pending=%0d required 0/0", valid, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overflow();
        test_timeout();
        test_glitch();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
